// File: rtl/altsyncram_dp.sv
// Simple dual-port RAM: write on port A, registered read on port B.
// Define ALTSYNCRAM_OUTREG_EN for an extra q_b output register.
module altsyncram_dp #(
  parameter OPERATION_MODE = "DUAL_PORT",
  parameter int WIDTH_A = 32,
  parameter int WIDTHAD_A = 10,
  parameter int WIDTH_B = 32,
  parameter int WIDTHAD_B = 10,
  parameter READ_DURING_WRITE_MIXED_PORTS = "DONT_CARE"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wren_a,
  input  logic [WIDTHAD_A-1:0] address_a,
  input  logic [WIDTH_A-1:0]   data_a,
  output logic [WIDTH_A-1:0]   q_a,
  input  logic                 rden_b,
  input  logic [WIDTHAD_B-1:0] address_b,
  output logic [WIDTH_B-1:0]   q_b
);

  localparam int DEPTH = 2 ** WIDTHAD_A;

  localparam bit POL_NEW =
    (READ_DURING_WRITE_MIXED_PORTS == "NEW_DATA");
  localparam bit POL_OLD =
    (READ_DURING_WRITE_MIXED_PORTS == "OLD_DATA");
  localparam bit POL_DC =
    (READ_DURING_WRITE_MIXED_PORTS == "DONT_CARE");

  if (OPERATION_MODE != "DUAL_PORT") begin : g_bad_mode
    $error("altsyncram_dp: only DUAL_PORT supported");
  end
  if (WIDTH_B != WIDTH_A) begin : g_bad_width
    $error("altsyncram_dp: WIDTH_B must equal WIDTH_A");
  end
  if (WIDTHAD_B != WIDTHAD_A) begin : g_bad_addr
    $error("altsyncram_dp: WIDTHAD_B must equal WIDTHAD_A");
  end
  if (!(POL_NEW || POL_OLD || POL_DC)) begin : g_bad_pol
    $error("altsyncram_dp: bad collision policy");
  end

  logic [WIDTH_A-1:0] mem [DEPTH];
  logic [WIDTH_B-1:0] rd_q;
  logic [WIDTH_B-1:0] rd_next;
  logic               coll;

  assign q_a  = '0;
  assign coll = wren_a && (address_a == address_b);

  // Port B read value, resolving a same-address write per policy
  always_comb begin
    rd_next = mem[address_b];
    if (coll) begin
      if (POL_NEW) begin
        rd_next = data_a;
      end else if (!POL_OLD) begin
        rd_next = 'x;
      end
    end
  end

  // Port A write; array is never reset so contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && wren_a) begin
      mem[address_a] <= data_a;
    end
  end

  // Port B read register, held while rden_b is low
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rden_b) begin
      rd_q <= rd_next;
    end
  end

`ifdef ALTSYNCRAM_OUTREG_EN
  logic [WIDTH_B-1:0] out_q;

  // Free-running output stage adding one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign q_b = out_q;
`else
  assign q_b = rd_q;
`endif

endmodule

// File: tb/tb_altsyncram_dp.sv
// Directed bench for altsyncram_dp: NEW_DATA and OLD_DATA instances
// share stimulus; expected values are hand-computed constants.
module tb_altsyncram_dp;

`ifdef ALTSYNCRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wren_a;
  logic [9:0]  address_a;
  logic [31:0] data_a;
  logic        rden_b;
  logic [9:0]  address_b;
  logic [31:0] qa_new, qb_new;
  logic [31:0] qa_old, qb_old;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  altsyncram_dp #(
    .READ_DURING_WRITE_MIXED_PORTS("NEW_DATA")
  ) dut_new (
    .clk(clk), .reset(reset),
    .wren_a(wren_a), .address_a(address_a),
    .data_a(data_a), .q_a(qa_new),
    .rden_b(rden_b), .address_b(address_b),
    .q_b(qb_new)
  );

  altsyncram_dp #(
    .READ_DURING_WRITE_MIXED_PORTS("OLD_DATA")
  ) dut_old (
    .clk(clk), .reset(reset),
    .wren_a(wren_a), .address_a(address_a),
    .data_a(data_a), .q_a(qa_old),
    .rden_b(rden_b), .address_b(address_b),
    .q_b(qb_old)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0;
    rden_b = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a,
                    input logic [31:0] d);
    wren_a = 1'b1;
    address_a = a;
    data_a = d;
    step();
    idle();
  endtask

  task automatic rd(input string tag,
                    input logic [9:0] a,
                    input logic [31:0] exp);
    rden_b = 1'b1;
    address_b = a;
    step();
    idle();
    repeat (LAT - 1) step();
    chk({tag, "_new"}, qb_new, exp);
    chk({tag, "_old"}, qb_old, exp);
  endtask

  task automatic wr_rd(input string tag,
                       input logic [9:0] wa,
                       input logic [31:0] d,
                       input logic [9:0] ra,
                       input logic [31:0] exp);
    wren_a = 1'b1;
    address_a = wa;
    data_a = d;
    rden_b = 1'b1;
    address_b = ra;
    step();
    idle();
    repeat (LAT - 1) step();
    chk({tag, "_new"}, qb_new, exp);
    chk({tag, "_old"}, qb_old, exp);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    address_a = '0;
    address_b = '0;
    data_a = '0;
    step();
    step();
    chk("rst_qb_new", qb_new, 32'h0);
    chk("rst_qb_old", qb_old, 32'h0);
    chk("rst_qa", qa_new | qa_old, 32'h0);
    reset = 1'b0;

    // basic write then read
    wr(10'd5, 32'hDEADBEEF);
    rd("basic", 10'd5, 32'hDEADBEEF);

    // same-address collision
    wr(10'd7, 32'h11111111);
    wren_a = 1'b1;
    address_a = 10'd7;
    data_a = 32'h22222222;
    rden_b = 1'b1;
    address_b = 10'd7;
    step();
    idle();
    repeat (LAT - 1) step();
    chk("coll_new", qb_new, 32'h22222222);
    chk("coll_old", qb_old, 32'h11111111);
    rd("coll_after", 10'd7, 32'h22222222);

    // read hold while rden_b low
    wr(10'd3, 32'h0000ABCD);
    rd("hold_pre", 10'd3, 32'h0000ABCD);
    for (int i = 0; i < 4; i++) begin
      wr(10'd3, 32'h00001234);
      chk("hold_new", qb_new, 32'h0000ABCD);
      chk("hold_old", qb_old, 32'h0000ABCD);
    end
    rd("hold_post", 10'd3, 32'h00001234);

    // reset clears q_b, blocks write, keeps memory
    wr(10'd0, 32'hA0A00001);
    wr(10'd9, 32'h5A5A5A5A);
    rd("pre_rst", 10'd9, 32'h5A5A5A5A);
    reset = 1'b1;
    wren_a = 1'b1;
    address_a = 10'd0;
    data_a = 32'hFFFFFFFF;
    rden_b = 1'b1;
    address_b = 10'd9;
    step();
    chk("rst2_new", qb_new, 32'h0);
    chk("rst2_old", qb_old, 32'h0);
    chk("rst2_qa", qa_new | qa_old, 32'h0);
    reset = 1'b0;
    idle();
    rd("post_rst", 10'd0, 32'hA0A00001);
    chk("qa_late", qa_new | qa_old, 32'h0);

    // boundaries with concurrent reads elsewhere
    wr_rd("b0", 10'd0, 32'h0BAD0000,
          10'd5, 32'hDEADBEEF);
    wr_rd("b1023", 10'd1023, 32'h0000F00D,
          10'd0, 32'h0BAD0000);
    rd("r1023", 10'd1023, 32'h0000F00D);
    rd("r0", 10'd0, 32'h0BAD0000);
    rd("r7", 10'd7, 32'h22222222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
